// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encodings, Nk/Nr lookup,
// round-constant seed and the GF(2^8) doubling used to advance Rcon.
package aes_pkg;

   typedef enum logic [1:0] {
      KL_128  = 2'b00,
      KL_192  = 2'b01,
      KL_256  = 2'b10,
      KL_RSVD = 2'b11
   } key_len_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_EXPAND = 1'b1
   } state_e;

   localparam int         NUM_WORDS = 60;
   localparam logic [7:0] RCON_INIT = 8'h01;

   function automatic logic [3:0] nk_of(input logic [1:0] kl);
      case (kl)
         KL_192:  return 4'd6;
         KL_256:  return 4'd8;
         default: return 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input logic [1:0] kl);
      case (kl)
         KL_192:  return 4'd12;
         KL_256:  return 4'd14;
         default: return 4'd10;
      endcase
   endfunction

   function automatic int key_bits_of(input logic [1:0] kl);
      case (kl)
         KL_128:  return 128;
         KL_192:  return 192;
         KL_256:  return 256;
         default: return 0;
      endcase
   endfunction

   // Multiply by x in GF(2^8), reducing with the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
   input  logic [7:0] data,
   output logic [7:0] sub
);

   // Entry 0 occupies the top byte, so entry x sits at byte position 255-x.
   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign sub = SBOX[{~data, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_sched.sv
// AES-128/192/256 key expansion: one schedule word per cycle into a 60-word
// register array, with a random-access round-key read port.
module aes_key_sched
   import aes_pkg::*;
#(
   parameter int MAX_KEY_BITS = 256,
   parameter int RD_LATENCY   = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [1:0]   key_len,
   input  logic [255:0] key,
   output logic         busy,
   output logic         done,
   output logic         key_ready,
   output logic         err,
   input  logic [3:0]   rd_round,
   output logic [127:0] rd_key
);

   state_e      state_q, state_d;
   logic [31:0] w_q [NUM_WORDS];
   logic [5:0]  idx_q;
   logic [2:0]  phase_q;
   logic [7:0]  rcon_q;
   logic [1:0]  len_q;
   logic        done_q, ready_q, err_q;

   logic        len_ok, accept, reject, last_word;
   logic [3:0]  nk_new, nk_cur, nr_cur, phase_inc;
   logic [31:0] prev_word, back_word, rot_word, sub_word, temp_word, new_word;

   assign nk_new    = nk_of(key_len);
   assign nk_cur    = nk_of(len_q);
   assign nr_cur    = nr_of(len_q);
   assign len_ok    = (key_len != KL_RSVD) && (key_bits_of(key_len) <= MAX_KEY_BITS);
   assign accept    = (state_q == ST_IDLE) && start && len_ok;
   assign reject    = (state_q == ST_IDLE) && start && !len_ok;
   assign last_word = (idx_q == {nr_cur, 2'b11});
   assign phase_inc = {1'b0, phase_q} + 4'd1;

   // Recurrence operands: w[i-1] and w[i-Nk]; phase_q tracks i mod Nk.
   assign prev_word = w_q[idx_q - 6'd1];
   assign back_word = w_q[idx_q - {2'b00, nk_cur}];
   assign rot_word  = (phase_q == 3'd0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      aes_sbox u_sbox (
         .data (rot_word[8*b +: 8]),
         .sub  (sub_word[8*b +: 8])
      );
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      temp_word = prev_word;
      if (phase_q == 3'd0)
         temp_word = sub_word ^ {rcon_q, 24'h0};
      else if (nk_cur == 4'd8 && phase_q == 3'd4)
         temp_word = sub_word;
   end

   assign new_word = back_word ^ temp_word;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = ST_EXPAND;
         ST_EXPAND: if (last_word) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // NOTE: the word array is reset because software may read it before any expansion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NUM_WORDS; j++) w_q[j] <= '0;
         idx_q   <= '0;
         phase_q <= '0;
         rcon_q  <= RCON_INIT;
         len_q   <= KL_128;
         done_q  <= 1'b0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= reject;
         if (accept) begin
            for (int j = 0; j < 8; j++)
               if (j < int'(nk_new)) w_q[j] <= key[255 - 32*j -: 32];
            len_q   <= key_len;
            idx_q   <= {2'b00, nk_new};
            phase_q <= 3'd0;
            rcon_q  <= RCON_INIT;
            ready_q <= 1'b0;
         end else if (state_q == ST_EXPAND) begin
            w_q[idx_q] <= new_word;
            idx_q      <= idx_q + 6'd1;
            phase_q    <= (phase_inc == nk_cur) ? 3'd0 : phase_inc[2:0];
            if (phase_q == 3'd0) rcon_q <= xtime(rcon_q);
            if (last_word) begin
               done_q  <= 1'b1;
               ready_q <= 1'b1;
            end
         end
      end
   end

   assign busy      = (state_q == ST_EXPAND);
   assign done      = done_q;
   assign key_ready = ready_q;
   assign err       = err_q;

   // Read port: rounds beyond the latched Nr read as zero.
   logic [5:0]   rd_base;
   logic [127:0] rd_data;

   assign rd_base = {rd_round, 2'b00};

   always_comb begin
      rd_data = '0;
      if (rd_round <= nr_cur)
         rd_data = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
   end

   if (RD_LATENCY == 0) begin : g_rd_comb
      assign rd_key = rd_data;
   end else begin : g_rd_reg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) rd_key <= '0;
         else        rd_key <= rd_data;
      end
   end

endmodule

// File: tb/tb_aes_key_sched.sv
// Randomised scoreboard bench for aes_key_sched against a FIPS-197 style
// model built from GF(2^8) arithmetic, plus the published golden vectors.
module tb_aes_key_sched;

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [127:0] G128_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] G128_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] G192_R12 = 128'he98ba06f448c773c8ecc720401002202;
   localparam logic [127:0] G256_R14 = 128'hfe4890d1e6188d0b046df344706c631e;

   localparam logic [1:0] EV_NONE = 2'b00;
   localparam logic [1:0] EV_DONE = 2'b01;
   localparam logic [1:0] EV_ERR  = 2'b10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   key_len = 2'b00;
   logic [255:0] key = '0;
   logic         busy, done, key_ready, err;
   logic [3:0]   rd_round = 4'd0;
   logic [127:0] rd_key;

   aes_key_sched #(.MAX_KEY_BITS(256), .RD_LATENCY(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .key_len   (key_len),
      .key       (key),
      .busy      (busy),
      .done      (done),
      .key_ready (key_ready),
      .err       (err),
      .rd_round  (rd_round),
      .rd_key    (rd_key)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      check(name, {127'd0, act}, {127'd0, exp});
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      check(name, 128'(act), 128'(exp));
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  sbox_ref [256];
   logic [7:0]  rcon_tab [16];
   logic [31:0] ref_w    [60];
   int          ref_nr = 10;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int n = 0; n < 8; n++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   task automatic build_tables();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
      rcon_tab[0] = 8'h00;
      rcon_tab[1] = 8'h01;
      for (int j = 2; j < 16; j++) rcon_tab[j] = gmul(rcon_tab[j-1], 8'h02);
   endtask

   function automatic logic [31:0] sub_w(input logic [31:0] v);
      return {sbox_ref[v[31:24]], sbox_ref[v[23:16]], sbox_ref[v[15:8]], sbox_ref[v[7:0]]};
   endfunction

   task automatic model_expand(input logic [1:0] kl, input logic [255:0] k);
      int          nk;
      logic [31:0] t;
      nk     = 4 + 2 * int'(kl);
      ref_nr = nk + 6;
      for (int i = 0; i < 60; i++) ref_w[i] = '0;
      for (int i = 0; i < nk; i++) ref_w[i] = k[255 - 32*i -: 32];
      for (int i = nk; i < 4 * (ref_nr + 1); i++) begin
         t = ref_w[i-1];
         if (i % nk == 0)
            t = sub_w({t[23:0], t[31:24]}) ^ {rcon_tab[i / nk], 24'h0};
         else if (nk == 8 && i % nk == 4)
            t = sub_w(t);
         ref_w[i] = ref_w[i-nk] ^ t;
      end
   endtask

   function automatic logic [127:0] exp_round(input int r);
      if (r > ref_nr) return '0;
      return {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]};
   endfunction

   function automatic int exp_latency(input logic [1:0] kl);
      int nk = 4 + 2 * int'(kl);
      return 4 * (nk + 7) - nk + 1;
   endfunction

   function automatic logic [255:0] rand_key();
      return {$urandom(), $urandom(), $urandom(), $urandom(),
              $urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct {
      logic [1:0] kind;
      int         start_cyc;
      int         lat;
   } ev_t;

   typedef struct {
      int           round;
      logic [127:0] val;
   } rd_t;

   ev_t  ev_q [$];
   rd_t  rd_q [$];
   ev_t  mon_e;
   rd_t  mon_r;
   logic rd_req   = 1'b0;
   logic rd_req_d = 1'b0;

   always @(posedge clk) rd_req_d <= rd_req;

   always @(negedge clk) begin
      if (rst_n && (done || err)) begin
         if (ev_q.size() > 0) mon_e = ev_q.pop_front();
         else                 mon_e = '{kind: EV_NONE, start_cyc: 0, lat: 0};
         check("event_kind", {126'd0, err, done}, {126'd0, mon_e.kind});
         if (mon_e.kind != EV_NONE)
            check_int("event_latency", cyc - mon_e.start_cyc, mon_e.lat);
      end
      if (rst_n && rd_req_d && rd_q.size() > 0) begin
         mon_r = rd_q.pop_front();
         check($sformatf("rd_round%0d", mon_r.round), rd_key, mon_r.val);
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_start(input logic [1:0] kl, input logic [255:0] k, input logic [1:0] kind);
      ev_t e;
      @(negedge clk);
      start   = 1'b1;
      key_len = kl;
      key     = k;
      if (kind != EV_NONE) begin
         e.kind      = kind;
         e.start_cyc = cyc;
         e.lat       = (kind == EV_ERR) ? 1 : exp_latency(kl);
         ev_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         seen = done;
      end
      if (!seen) check_bit("done_timeout", done, 1'b1);
      check_bit("ready_at_done", key_ready, 1'b1);
      check_bit("busy_at_done", busy, 1'b0);
   endtask

   task automatic rd_issue(input int r, input logic [127:0] v);
      rd_t e;
      @(negedge clk);
      rd_round = 4'(r);
      rd_req   = 1'b1;
      e.round  = r;
      e.val    = v;
      rd_q.push_back(e);
   endtask

   task automatic rd_flush();
      @(negedge clk);
      rd_req = 1'b0;
   endtask

   task automatic read_all();
      for (int r = 0; r < 16; r++) rd_issue(r, exp_round(r));
   endtask

   task automatic run_schedule(input logic [1:0] kl, input logic [255:0] k);
      model_expand(kl, k);
      do_start(kl, k, EV_DONE);
      check_bit("busy_after_start", busy, 1'b1);
      check_bit("ready_cleared", key_ready, 1'b0);
      wait_done();
      read_all();
   endtask

   initial begin
      build_tables();

      repeat (3) @(negedge clk);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_ready", key_ready, 1'b0);
      check_bit("rst_err", err, 1'b0);
      check("rst_rd_key", rd_key, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Golden 128-bit vector.
      run_schedule(2'b00, K128);
      rd_issue(1, G128_R1);
      rd_issue(10, G128_R10);
      rd_flush();

      // Golden 192-bit vector, including a read past Nr.
      run_schedule(2'b01, K192);
      rd_issue(12, G192_R12);
      rd_issue(13, '0);
      rd_flush();

      // Golden 256-bit vector with starts attempted mid-expansion.
      model_expand(2'b10, K256);
      do_start(2'b10, K256, EV_DONE);
      repeat (8) @(negedge clk);
      start = 1'b1; key_len = 2'b00; key = ~K256;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1; key_len = 2'b11;
      @(negedge clk);
      start = 1'b0;
      check_bit("busy_mid_expand", busy, 1'b1);
      wait_done();
      read_all();
      rd_issue(14, G256_R14);
      rd_flush();

      // Reserved length: error pulse, schedule retained.
      do_start(2'b11, rand_key(), EV_ERR);
      check_bit("rsvd_busy", busy, 1'b0);
      check_bit("rsvd_ready", key_ready, 1'b1);
      repeat (2) @(negedge clk);
      check_bit("rsvd_busy_later", busy, 1'b0);
      rd_issue(14, G256_R14);
      rd_issue(3, exp_round(3));
      rd_flush();

      // Reset in the middle of a 256-bit expansion.
      do_start(2'b10, rand_key(), EV_NONE);
      repeat (19) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_bit("abort_busy", busy, 1'b0);
      check_bit("abort_done", done, 1'b0);
      check_bit("abort_ready", key_ready, 1'b0);
      check_bit("abort_err", err, 1'b0);
      check("abort_rd_key", rd_key, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      check_bit("abort_idle", busy, 1'b0);
      check_bit("abort_no_ready", key_ready, 1'b0);

      // Fresh 128-bit expansion after the abort.
      run_schedule(2'b00, K128);
      rd_issue(1, G128_R1);
      rd_issue(10, G128_R10);
      rd_flush();

      // Back-to-back: second start the cycle after done.
      model_expand(2'b01, rand_key());
      do_start(2'b01, {ref_w[0], ref_w[1], ref_w[2], ref_w[3], ref_w[4], ref_w[5], 64'h0}, EV_DONE);
      wait_done();
      begin
         logic [255:0] kb;
         kb = rand_key();
         model_expand(2'b10, kb);
         do_start(2'b10, kb, EV_DONE);
      end
      check_bit("b2b_ready_drop", key_ready, 1'b0);
      check_bit("b2b_busy", busy, 1'b1);
      wait_done();
      read_all();
      rd_flush();

      // Randomised keys and lengths.
      for (int it = 0; it < 4; it++) begin
         run_schedule(2'($urandom_range(0, 2)), rand_key());
         rd_flush();
      end

      repeat (5) @(negedge clk);
      check_int("events_drained", ev_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1, "watchdog expired");
   end

endmodule
